// File: rtl/uc_pilha.sv
// Stack-datapath control sequencer: takes one instruction at a time and emits
// registered single-cycle strobes, guarding a shadow depth counter against under/overflow.
module uc_pilha #(
  parameter int DEPTH = 16,
  parameter int DW    = 16,
  localparam int AW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [4:0]    instr_op,
  input  logic [DW-1:0] instr_imm,
  output logic          wren,
  output logic          controle_pilha,
  output logic          clk_pilha,
  output logic          clk_temp1,
  output logic          clk_temp2,
  output logic          load_temp1,
  output logic          load_temp2,
  output logic [DW-1:0] din_UC,
  output logic [4:0]    opcode,
  output logic [AW-1:0] depth,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PUSH = 3'd1;
  localparam logic [2:0] S_POP  = 3'd2;
  localparam logic [2:0] S_CAP2 = 3'd3;
  localparam logic [2:0] S_POP2 = 3'd4;
  localparam logic [2:0] S_CAP1 = 3'd5;
  localparam logic [2:0] S_POP1 = 3'd6;
  localparam logic [2:0] S_WB   = 3'd7;

  localparam logic [AW-1:0] FULL = AW'(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [DW-1:0] din_q, din_d;
  logic [4:0]    opc_q, opc_d;
  logic          ready_q, wren_q, ctrl_q, pilha_q, t1_q, t2_q;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; ready is high only while the FSM is in IDLE.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    err_d   = err_q;
    code_d  = code_q;
    din_d   = din_q;
    opc_d   = opc_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (instr_op == 5'd0) begin
            state_d = S_IDLE;
          end else if (instr_op == 5'd1) begin
            if (depth_q < FULL) begin
              state_d = S_PUSH;
              din_d   = instr_imm;
            end else begin
              err_d = 1'b1;
              if (!err_q) code_d = 2'b10;
            end
          end else if (instr_op == 5'd2) begin
            if (depth_q >= AW'(1)) begin
              state_d = S_POP;
            end else begin
              err_d = 1'b1;
              if (!err_q) code_d = 2'b01;
            end
          end else if (instr_op >= 5'd3 && instr_op <= 5'd10) begin
            if (depth_q >= AW'(2)) begin
              state_d = S_CAP2;
              opc_d   = instr_op;
            end else begin
              err_d = 1'b1;
              if (!err_q) code_d = 2'b01;
            end
          end else begin
            err_d = 1'b1;
            if (!err_q) code_d = 2'b11;
          end
        end
      end
      S_PUSH: begin
        state_d = S_IDLE;
        depth_d = depth_q + AW'(1);
      end
      S_POP: begin
        state_d = S_IDLE;
        depth_d = depth_q - AW'(1);
      end
      S_CAP2: state_d = S_POP2;
      S_POP2: state_d = S_CAP1;
      S_CAP1: state_d = S_POP1;
      S_POP1: state_d = S_WB;
      S_WB: begin
        state_d = S_IDLE;
        depth_d = depth_q - AW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so each is a clean
  // flop output that is high exactly during its state's cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      din_q   <= '0;
      opc_q   <= 5'd0;
      ready_q <= 1'b1;
      wren_q  <= 1'b0;
      ctrl_q  <= 1'b0;
      pilha_q <= 1'b0;
      t1_q    <= 1'b0;
      t2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      code_q  <= code_d;
      din_q   <= din_d;
      opc_q   <= opc_d;
      ready_q <= (state_d == S_IDLE);
      wren_q  <= (state_d == S_PUSH) || (state_d == S_WB);
      ctrl_q  <= (state_d == S_WB);
      pilha_q <= (state_d == S_PUSH) || (state_d == S_POP) || (state_d == S_POP2) ||
                 (state_d == S_POP1) || (state_d == S_WB);
      t1_q    <= (state_d == S_CAP1);
      t2_q    <= (state_d == S_CAP2);
    end
  end

  assign instr_ready    = ready_q;
  assign wren           = wren_q;
  assign controle_pilha = ctrl_q;
  assign clk_pilha      = pilha_q;
  assign clk_temp1      = t1_q;
  assign load_temp1     = t1_q;
  assign clk_temp2      = t2_q;
  assign load_temp2     = t2_q;
  assign din_UC         = din_q;
  assign opcode         = opc_q;
  assign depth          = depth_q;
  assign err            = err_q;
  assign err_code       = code_q;
  assign dbg_state      = state_q;

endmodule
